// File: rtl/tt_load_drain_ctrl.sv
// tt_load_drain_ctrl
// Load-queue side of the scoreboard drain handshake. Accepts one drain request
// (start lqid, entry count, sb_id) while idle, then walks the load queue in
// circular order. Each ready entry is moved into a one-entry output register
// that feeds the VRF write-back port. Every accepted write-back beat produces a
// one-cycle lq_commit pulse, which retires that entry in the scoreboard.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   i_drain_req/lqid_start/ drain request from the scoreboard, held until it is
//   ref_count/sb_id         accepted (req && !o_draining)
//   o_draining              high while a drain is in progress
//   o_load_sb_id, i_vd      scoreboard lookup of the destination register
//   o_lq_rd_id, i_lq_*      load-queue read address, ready flags, read data
//   o_wb_*, i_wb_ready      write-back beat (valid/ready handshake)
//   o_lq_commit(_id)        one entry retired (combinational)
module tt_load_drain_ctrl #(
    parameter int unsigned LQ_DEPTH   = 8,
    parameter int unsigned LQID_W     = 3,
    parameter int unsigned DATA_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_drain_req,
    input  logic [LQID_W-1:0]     i_drain_lqid_start,
    input  logic [LQID_W:0]       i_drain_ref_count,
    input  logic [4:0]            i_drain_sb_id,
    output logic                  o_draining,
    output logic [4:0]            o_load_sb_id,
    input  logic [4:0]            i_vd,
    output logic [LQID_W-1:0]     o_lq_rd_id,
    input  logic [LQ_DEPTH-1:0]   i_lq_entry_ready,
    input  logic [DATA_WIDTH-1:0] i_lq_rd_data,
    output logic                  o_wb_valid,
    output logic [DATA_WIDTH-1:0] o_wb_data,
    output logic [4:0]            o_wb_vd,
    output logic [LQID_W-1:0]     o_wb_lqid,
    output logic                  o_wb_last,
    input  logic                  i_wb_ready,
    output logic                  o_lq_commit,
    output logic [LQID_W-1:0]     o_lq_commit_id
);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StActive = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [LQID_W-1:0]     cur_id_q, cur_id_d;
    logic [LQID_W:0]       remaining_q, remaining_d;
    logic [4:0]            sb_id_q, sb_id_d;
    logic [4:0]            vd_q, vd_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [4:0]            wb_vd_q, wb_vd_d;
    logic [LQID_W-1:0]     wb_lqid_q, wb_lqid_d;
    logic                  wb_last_q, wb_last_d;

    logic active;
    logic wb_accept;
    logic fetch;
    logic done;

    assign active    = (state_q == StActive);
    assign wb_accept = wb_valid_q && i_wb_ready;
    // The output register can take a new entry if it is empty or draining this cycle.
    assign fetch     = active && (remaining_q != '0) && i_lq_entry_ready[cur_id_q]
                       && (!wb_valid_q || i_wb_ready);
    // With nothing left to fetch, any beat still held is necessarily the last one.
    assign done      = active && (remaining_q == '0) && (!wb_valid_q || i_wb_ready);

    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        remaining_d = remaining_q;
        sb_id_d     = sb_id_q;
        vd_d        = vd_q;
        wb_valid_d  = wb_valid_q;
        wb_data_d   = wb_data_q;
        wb_vd_d     = wb_vd_q;
        wb_lqid_d   = wb_lqid_q;
        wb_last_d   = wb_last_q;

        if (state_q == StIdle) begin
            if (i_drain_req) begin
                state_d     = StActive;
                cur_id_d    = i_drain_lqid_start;
                remaining_d = i_drain_ref_count;
                sb_id_d     = i_drain_sb_id;
                // i_vd is looked up with o_load_sb_id = i_drain_sb_id while idle.
                vd_d        = i_vd;
            end
        end else begin
            if (wb_accept) begin
                wb_valid_d = 1'b0;
                wb_last_d  = 1'b0;
            end
            if (fetch) begin
                wb_valid_d  = 1'b1;
                wb_data_d   = i_lq_rd_data;
                wb_vd_d     = vd_q;
                wb_lqid_d   = cur_id_q;
                wb_last_d   = (remaining_q == {{LQID_W{1'b0}}, 1'b1});
                // LQ_DEPTH is a power of two, so natural overflow is the circular wrap.
                cur_id_d    = cur_id_q + {{(LQID_W-1){1'b0}}, 1'b1};
                remaining_d = remaining_q - {{LQID_W{1'b0}}, 1'b1};
            end
            if (done) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cur_id_q    <= '0;
            remaining_q <= '0;
            sb_id_q     <= '0;
            vd_q        <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_vd_q     <= '0;
            wb_lqid_q   <= '0;
            wb_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_id_q    <= cur_id_d;
            remaining_q <= remaining_d;
            sb_id_q     <= sb_id_d;
            vd_q        <= vd_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_vd_q     <= wb_vd_d;
            wb_lqid_q   <= wb_lqid_d;
            wb_last_q   <= wb_last_d;
        end
    end

    always_comb begin
        o_draining     = active;
        o_load_sb_id   = active ? sb_id_q : i_drain_sb_id;
        o_lq_rd_id     = cur_id_q;
        o_wb_valid     = wb_valid_q;
        o_wb_data      = wb_data_q;
        o_wb_vd        = wb_vd_q;
        o_wb_lqid      = wb_lqid_q;
        o_wb_last      = wb_last_q;
        o_lq_commit    = wb_accept;
        o_lq_commit_id = wb_lqid_q;
    end

endmodule

// File: doc/tt_load_drain_ctrl.md
Name: tt_load_drain_ctrl

Overview:
Load-queue side of the scoreboard drain handshake. It accepts one drain request (start lqid, entry count, sb_id), then walks the load queue in circular order. Each filled entry is forwarded through a one-entry output register to the VRF write-back port. One lq_commit pulse is issued per accepted write-back, which decrements the scoreboard ref_count. Sits between the OVI scoreboard, the load-queue data array and the vector register write port.

Parameters:
LQ_DEPTH, 8, number of load-queue entries; power of two.
LQID_W, 3, log2(LQ_DEPTH).
DATA_WIDTH, 512, bits per load-queue entry / write-back beat.

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
i_drain_req  input  1  scoreboard requests a drain; held until it sees acceptance
i_drain_lqid_start  input  LQID_W  first lqid of the instruction
i_drain_ref_count  input  LQID_W+1  entries to drain, 0..LQ_DEPTH
i_drain_sb_id  input  5  sb_id of the instruction being drained
o_draining  output  1  high while a drain is active
o_load_sb_id  output  5  sb_id for the scoreboard vd/size lookup
i_vd  input  5  vd returned by the scoreboard for o_load_sb_id (combinational)
o_lq_rd_id  output  LQID_W  load-queue entry currently addressed
i_lq_entry_ready  input  LQ_DEPTH  per-entry "data arrived" flags
i_lq_rd_data  input  DATA_WIDTH  combinational read data for o_lq_rd_id
o_wb_valid  output  1  write-back beat valid
o_wb_data  output  DATA_WIDTH  write-back data
o_wb_vd  output  5  destination vector register
o_wb_lqid  output  LQID_W  source lqid of the beat
o_wb_last  output  1  final beat of this drain
i_wb_ready  input  1  write port accepts the beat
o_lq_commit  output  1  one entry retired
o_lq_commit_id  output  LQID_W  lqid retired

Behaviour:
- Clock and reset: clk; reset reset_n, synchronous, active-low.
- Reset values: state IDLE; o_draining=0; o_wb_valid=0; o_wb_last=0; o_lq_commit=0. All id, count and data registers are 0.
- Reset mid-drain: the drain is abandoned immediately and the block returns to IDLE. The pending beat is dropped and no commit is issued.
- FSM states:
  - IDLE: o_draining=0. Acceptance happens in the cycle i_drain_req=1 while in IDLE. In that same cycle, o_draining is still 0; the scoreboard uses req && !draining to mark the entry drained. On acceptance, latch cur_id=lqid_start, remaining=ref_count, sb_id and vd (i_vd sampled with o_load_sb_id=i_drain_sb_id). Next state is ACTIVE.
  - ACTIVE: o_draining=1 and o_load_sb_id=latched sb_id; o_lq_rd_id=cur_id.
    - Fetch condition: remaining!=0, i_lq_entry_ready[cur_id]=1, and the output register is empty or being accepted this cycle.
    - On fetch: load the output register (data, vd, lqid=cur_id, last=(remaining==1)). Then cur_id = cur_id+1 mod LQ_DEPTH (wrap 7->0) and remaining--.
    - Exit: when remaining==0 and the output register is empty (or its last beat is accepted this cycle), the next state is IDLE.
  - Idle outputs: in IDLE, o_load_sb_id=i_drain_sb_id.
- Output register:
  - o_wb_valid holds with stable data until i_wb_ready=1.
  - Accept and refill in the same cycle is allowed, giving one beat per cycle sustained.
- Commit: o_lq_commit = o_wb_valid && i_wb_ready (combinational), with o_lq_commit_id=o_wb_lqid. Exactly ref_count commits occur per drain.
- Latency: entry ready at cycle t gives o_wb_valid at t+1.
- Boundary: ref_count=0 means accept, then one ACTIVE cycle, then IDLE, with no beats and no commits.
- Boundary: ref_count=LQ_DEPTH drains all entries, wrapping fully once.
- Boundary: i_drain_req while not IDLE is ignored; no new latch occurs.
- Boundary: if an entry is not ready, the walk stalls on that entry indefinitely. Entries are never skipped or reordered.
- Boundary: i_lq_entry_ready bits for non-addressed entries are ignored.

Test Plan:
1. Basic drain: start=2, count=3, all entries ready, wb_ready=1. Expect accept cycle with o_draining=0, then three beats with lqid 2,3,4 on consecutive cycles and last=1 on lqid 4. Expect commits 2,3,4 and return to IDLE the cycle after the last commit.
2. Wrap: start=6, count=4. Expect beats with lqid 6,7,0,1; commit_id follows the same order.
3. Backpressure: start=0, count=2, wb_ready low for 3 cycles. Expect o_wb_valid/data/lqid stable for those cycles, no commits until ready, and lqid 1 not fetched early.
4. Stall: start=3, count=2, entry 3 ready at cycle 5. Expect no o_wb_valid before cycle 6. Set ready[4]=1 while 3 is still unready; expect no reorder.
5. Edge: count=0 gives o_draining high for exactly one cycle and zero commits. count=8 from start 5 gives 8 beats, ending at lqid 4.
6. Reset while ACTIVE with a pending beat: the next cycle has o_wb_valid=0, o_draining=0 and no commit. A fresh request afterwards drains correctly.
